// File: rtl/led_frame_sequencer.sv
// Walks the colour ROM once per frame, offers each GRB word over valid/ready,
// then holds the WS2812b latch gap before starting the next frame.
module led_frame_sequencer #(
  parameter int ADDR_W       = 5,
  parameter int NUM_LEDS     = 16,
  parameter int LATCH_CYCLES = 6000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_scroll,
  output logic [ADDR_W-1:0] o_addr,
  input  logic [23:0]       i_rom_data,
  output logic [23:0]       o_grb_data,
  output logic              o_grb_valid,
  input  logic              i_grb_ready,
  output logic              o_latch,
  output logic              o_frame_done,
  output logic              o_busy
);

  localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, LATCH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pixel_idx_q, pixel_idx_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [23:0]       grb_q, grb_d;
  logic              valid_q, valid_d;
  logic              latch_q, latch_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    pixel_idx_d = pixel_idx_q;
    offset_d    = offset_q;
    cnt_d       = cnt_q;
    grb_d       = grb_q;
    case (state_q)
      IDLE: begin
        if (i_en) begin
          state_d     = FETCH;
          pixel_idx_d = '0;
        end
      end
      FETCH: begin
        grb_d   = i_rom_data;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (valid_q && i_grb_ready) begin
          if (pixel_idx_q == LAST_PIX) begin
            state_d = LATCH;
            cnt_d   = '0;
          end else begin
            pixel_idx_d = pixel_idx_q + 1'b1;
            state_d     = FETCH;
          end
        end
      end
      LATCH: begin
        if (cnt_q == LAST_CNT) begin
          pixel_idx_d = '0;
          if (i_scroll) offset_d = offset_q + 1'b1;
          state_d = i_en ? FETCH : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they come straight off flops.
    valid_d = (state_d == PRESENT);
    latch_d = (state_d == LATCH);
    done_d  = (state_d == LATCH) && (cnt_d == LAST_CNT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      pixel_idx_q <= '0;
      offset_q    <= '0;
      cnt_q       <= '0;
      grb_q       <= '0;
      valid_q     <= 1'b0;
      latch_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pixel_idx_q <= pixel_idx_d;
      offset_q    <= offset_d;
      cnt_q       <= cnt_d;
      grb_q       <= grb_d;
      valid_q     <= valid_d;
      latch_q     <= latch_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Carry is dropped so scrolled frames wrap around the ROM.
  assign o_addr       = pixel_idx_q + offset_q;
  assign o_grb_data   = grb_q;
  assign o_grb_valid  = valid_q;
  assign o_latch      = latch_q;
  assign o_frame_done = done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboard bench: three sequencer instances (16 LEDs, 1 LED, 16 LEDs with short gap)
// checked against a ROM model, latch gap lengths and handshake timing.
module tb_led_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[3], en[3], scroll[3], ready[3];
  logic [4:0]  addr[3];
  logic [23:0] grb[3], rom[3];
  logic        valid[3], latch[3], done[3], busy[3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int frames[3];
  int hs_cnt[3];
  int hs_last[3];
  int latch_run[3];
  logic [28:0] sb[3][$];

  function automatic logic [23:0] rom_fn(input logic [4:0] a);
    return {a, 3'b101, ~a, 3'b010, a ^ 5'h15, 3'b110};
  endfunction

  function automatic int lc(input int k);
    return (k == 2) ? 8 : 6000;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    led_frame_sequencer #(
      .ADDR_W(5),
      .NUM_LEDS(gi == 1 ? 1 : 16),
      .LATCH_CYCLES(gi == 2 ? 8 : 6000)
    ) u_dut (
      .i_clk(clk), .i_rst(rst[gi]), .i_en(en[gi]), .i_scroll(scroll[gi]),
      .o_addr(addr[gi]), .i_rom_data(rom[gi]), .o_grb_data(grb[gi]),
      .o_grb_valid(valid[gi]), .i_grb_ready(ready[gi]), .o_latch(latch[gi]),
      .o_frame_done(done[gi]), .o_busy(busy[gi])
    );
    assign rom[gi] = rom_fn(addr[gi]);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int k, input int off, input int n);
    for (int i = 0; i < n; i++) begin
      logic [4:0] a;
      a = 5'(i + off);
      sb[k].push_back({a, rom_fn(a)});
    end
  endtask

  task automatic wait_frames(input int k, input int target, input int limit);
    int n = 0;
    while (frames[k] < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout", 32'(frames[k] >= target), 1);
  endtask

  task automatic wait_valid(input int k, input int limit);
    int n = 0;
    while (!valid[k] && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", 32'(valid[k]), 1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor samples late in the low phase, after inputs settle and before the edge.
  always @(negedge clk) begin
    logic [28:0] exp_w;
    #3;
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        latch_run[k] = 0;
      end else begin
        if (valid[k] && ready[k]) begin
          check("sb_nonempty", 32'(sb[k].size() != 0), 1);
          if (sb[k].size() != 0) begin
            exp_w = sb[k].pop_front();
            check("hs_addr", 32'(addr[k]), 32'(exp_w[28:24]));
            check("hs_data", 32'(grb[k]), 32'(exp_w[23:0]));
          end
          if (k == 1 && hs_cnt[k] > 0) check("frame_period", cyc - hs_last[k], 6002);
          hs_cnt[k]++;
          hs_last[k] = cyc;
          $display("hs dut%0d addr=%0d data=%06h cyc=%0d", k, addr[k], grb[k], cyc);
        end
        if (latch[k]) latch_run[k]++;
        if (done[k]) begin
          frames[k]++;
          check("done_in_gap", 32'(latch[k]), 1);
          check("done_at_gap_end", latch_run[k], lc(k));
        end
        if (!latch[k] && latch_run[k] != 0) begin
          check("latch_len", latch_run[k], lc(k));
          latch_run[k] = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; en[k] = 1'b0; scroll[k] = 1'b0; ready[k] = 1'b0;
      frames[k] = 0; hs_cnt[k] = 0; hs_last[k] = 0; latch_run[k] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(addr[0]), 0);
    check("rst_data", 32'(grb[0]), 0);
    check("rst_valid", 32'(valid[0]), 0);
    check("rst_latch", 32'(latch[0]), 0);
    check("rst_done", 32'(done[0]), 0);
    for (int k = 0; k < 3; k++) check("rst_busy", 32'(busy[k]), 0);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    repeat (2) @(negedge clk);

    // Frame in order with ready tied high, plus enable-to-valid latency.
    push_frame(0, 0, 16);
    ready[0] = 1'b1;
    en[0] = 1'b1;
    @(posedge clk); #1;
    check("lat_valid_c1", 32'(valid[0]), 0);
    @(posedge clk); #1;
    check("lat_valid_c2", 32'(valid[0]), 1);
    @(negedge clk);
    en[0] = 1'b0;
    wait_frames(0, 1, 7000);
    @(negedge clk);
    check("t1_idle_busy", 32'(busy[0]), 0);

    // Backpressure: word and address held, exactly one word taken per ready pulse.
    push_frame(0, 0, 16);
    ready[0] = 1'b0;
    en[0] = 1'b1;
    wait_valid(0, 10);
    en[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(valid[0]), 1);
      check("hold_addr", 32'(addr[0]), 0);
      check("hold_data", 32'(grb[0]), 32'(rom_fn(5'd0)));
    end
    ready[0] = 1'b1;
    @(negedge clk);
    ready[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("one_taken_valid", 32'(valid[0]), 1);
    check("one_taken_addr", 32'(addr[0]), 1);
    ready[0] = 1'b1;
    wait_frames(0, 2, 7000);

    // Enable dropped during pixel 5: the frame and its gap still complete.
    push_frame(0, 0, 16);
    en[0] = 1'b1;
    f = 0;
    while (!(valid[0] && addr[0] == 5'd5) && f < 40) begin
      @(negedge clk);
      f++;
    end
    check("reach_pix5", 32'(addr[0]), 5);
    en[0] = 1'b0;
    wait_frames(0, 3, 7000);
    @(negedge clk);
    check("t4_idle_busy", 32'(busy[0]), 0);
    check("t4_sb_empty", 32'(sb[0].size()), 0);

    // Reset mid-gap clears everything at once and suppresses the frame pulse.
    push_frame(0, 0, 16);
    en[0] = 1'b1;
    f = 0;
    while (!latch[0] && f < 100) begin
      @(negedge clk);
      f++;
    end
    check("reach_latch", 32'(latch[0]), 1);
    en[0] = 1'b0;
    repeat (3000) @(negedge clk);
    f = frames[0];
    rst[0] = 1'b1;
    #1;
    check("mid_rst_latch", 32'(latch[0]), 0);
    check("mid_rst_busy", 32'(busy[0]), 0);
    check("mid_rst_done", 32'(done[0]), 0);
    check("mid_rst_valid", 32'(valid[0]), 0);
    check("mid_rst_addr", 32'(addr[0]), 0);
    check("mid_rst_data", 32'(grb[0]), 0);
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("no_done_after_rst", frames[0], f);
    push_frame(0, 0, 16);
    en[0] = 1'b1;
    repeat (3) @(negedge clk);
    en[0] = 1'b0;
    wait_frames(0, f + 1, 7000);

    // Single-LED frames: one handshake per frame, period 2 + gap.
    push_frame(1, 0, 1);
    push_frame(1, 0, 1);
    ready[1] = 1'b1;
    en[1] = 1'b1;
    f = 0;
    while (hs_cnt[1] < 2 && f < 7000) begin
      @(negedge clk);
      f++;
    end
    check("b_two_hs", hs_cnt[1], 2);
    en[1] = 1'b0;
    wait_frames(1, 2, 7000);

    // Scrolling through offset 33 exercises address and offset wrap.
    for (int o = 0; o < 34; o++) push_frame(2, o, 16);
    scroll[2] = 1'b1;
    ready[2] = 1'b1;
    en[2] = 1'b1;
    wait_frames(2, 33, 2000);
    en[2] = 1'b0;
    wait_frames(2, 34, 200);
    @(negedge clk);
    check("c_idle_busy", 32'(busy[2]), 0);

    for (int k = 0; k < 3; k++) check("sb_drained", 32'(sb[k].size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
